// File: rtl/sck_pkg.sv
// Shared constants, flag layout and result record for the sck ALU result path.
// The optional overflow counter (SCK_OVF_CNT_EN) uses the counter constants below.
package sck_pkg;

   localparam int SCK_DATA_W = 10;
   localparam int SCK_FLAG_W = 4;

   localparam int FLG_OVF  = 0;
   localparam int FLG_ZERO = 1;
   localparam int FLG_POS  = 2;
   localparam int FLG_NEG  = 3;

   localparam int         SCK_CNT_W   = 8;
   localparam logic [7:0] SCK_CNT_MAX = 8'hFF;

   typedef struct packed {
      logic signed [SCK_DATA_W-1:0] result;
      logic [SCK_FLAG_W-1:0]        flag;
   } sck_res_t;

   // Saturating increment: holds at SCK_CNT_MAX instead of wrapping to zero.
   function automatic logic [SCK_CNT_W-1:0] sat_inc(input logic [SCK_CNT_W-1:0] value);
      return (value == SCK_CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/sck_fifo_ptr.sv
// Read/write pointer pair with wrap bit, producing full/empty/level and the
// qualified push/pop strobes for a power-of-two FIFO of DEPTH entries.
module sck_fifo_ptr #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_req,
   input  logic          pop_req,
   output logic          push,
   output logic          pop,
   output logic          full,
   output logic          empty,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [PW-1:0] level
);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // The extra MSB distinguishes a full FIFO from an empty one when the addresses match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

   // No pass-through when full: a push is refused even if a pop frees a slot this cycle.
   assign push = push_req && !full;
   assign pop  = pop_req && !empty;

   assign wr_addr = wr_ptr[AW-1:0];
   assign rd_addr = rd_ptr[AW-1:0];
   assign level   = wr_ptr - rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sck_result_fifo.sv
// First-word-fall-through FIFO for ALU {result, flag} pairs with sticky OVF/NEG status.
// Define SCK_OVF_CNT_EN to add o_ovf_cnt, a saturating count of accepted OVF results.
module sck_result_fifo
   import sck_pkg::*;
#(
   parameter  int DATA_W = SCK_DATA_W,
   parameter  int FLAG_W = SCK_FLAG_W,
   parameter  int DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = AW + 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic signed [DATA_W-1:0] i_result,
   input  logic [FLAG_W-1:0]        i_flag,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic signed [DATA_W-1:0] o_result,
   output logic [FLAG_W-1:0]        o_flag,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [LW-1:0]            o_level,
   input  logic                     i_clr_sticky,
   output logic                     o_sticky_ovf,
`ifdef SCK_OVF_CNT_EN
   output logic [SCK_CNT_W-1:0]     o_ovf_cnt,
`endif
   output logic                     o_sticky_neg
);

   localparam int EW = DATA_W + FLAG_W;

   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic          set_ovf;
   logic          set_neg;

   sck_fifo_ptr #(
      .DEPTH(DEPTH)
   ) u_ptr (
      .clk     (i_clk),
      .rst     (i_rst),
      .push_req(i_valid),
      .pop_req (i_ready),
      .push    (push),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .wr_addr (wr_addr),
      .rd_addr (rd_addr),
      .level   (o_level)
   );

   assign o_ready = !full;
   assign o_valid = !empty;

   // Storage is deliberately not reset; stale entries are hidden by the empty mask below.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_addr] <= {i_result, i_flag};
      end
   end

   assign head     = empty ? '0 : mem[rd_addr];
   assign o_result = head[EW-1:FLAG_W];
   assign o_flag   = head[FLAG_W-1:0];

   assign set_ovf = push && i_flag[FLG_OVF];
   assign set_neg = push && i_flag[FLG_NEG];

   // A clear coinciding with a setting push leaves the bit set.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sticky_ovf <= 1'b0;
         o_sticky_neg <= 1'b0;
      end else if (i_clr_sticky) begin
         o_sticky_ovf <= set_ovf;
         o_sticky_neg <= set_neg;
      end else begin
         o_sticky_ovf <= o_sticky_ovf | set_ovf;
         o_sticky_neg <= o_sticky_neg | set_neg;
      end
   end

`ifdef SCK_OVF_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ovf_cnt <= '0;
      end else if (i_clr_sticky) begin
         o_ovf_cnt <= set_ovf ? SCK_CNT_W'(1) : '0;
      end else if (set_ovf) begin
         o_ovf_cnt <= sat_inc(o_ovf_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_sck_result_fifo.sv
// Self-checking bench for sck_result_fifo: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_sck_result_fifo;
   import sck_pkg::*;

   localparam int DEPTH = 4;

   logic                         i_clk;
   logic                         i_rst;
   logic signed [SCK_DATA_W-1:0] i_result;
   logic [SCK_FLAG_W-1:0]        i_flag;
   logic                         i_valid;
   logic                         o_ready;
   logic signed [SCK_DATA_W-1:0] o_result;
   logic [SCK_FLAG_W-1:0]        o_flag;
   logic                         o_valid;
   logic                         i_ready;
   logic [2:0]                   o_level;
   logic                         i_clr_sticky;
   logic                         o_sticky_ovf;
   logic                         o_sticky_neg;
`ifdef SCK_OVF_CNT_EN
   logic [7:0]                   o_ovf_cnt;
`endif

   int errors = 0;
   int checks = 0;

   sck_res_t model_q[$];
   logic     model_ovf;
   logic     model_neg;
   int       model_cnt;

   typedef struct {
      logic                         valid;
      logic signed [SCK_DATA_W-1:0] result;
      logic                         ready;
      int                           exp_level;
      logic                         exp_valid;
      logic                         exp_ready;
      logic signed [SCK_DATA_W-1:0] exp_head;
   } vec_t;

   vec_t fill_tab[9];

   sck_result_fifo #(
      .DATA_W(SCK_DATA_W),
      .FLAG_W(SCK_FLAG_W),
      .DEPTH (DEPTH)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_result    (i_result),
      .i_flag      (i_flag),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_result    (o_result),
      .o_flag      (o_flag),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_level     (o_level),
      .i_clr_sticky(i_clr_sticky),
      .o_sticky_ovf(o_sticky_ovf),
`ifdef SCK_OVF_CNT_EN
      .o_ovf_cnt   (o_ovf_cnt),
`endif
      .o_sticky_neg(o_sticky_neg)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      model_q.delete();
      model_ovf = 1'b0;
      model_neg = 1'b0;
      model_cnt = 0;
   endtask

   task automatic compareModel(input string tag);
      int size;
      size = model_q.size();
      checkOutput({tag, "_level"}, int'(o_level), size);
      checkOutput({tag, "_valid"}, int'(o_valid), (size > 0) ? 1 : 0);
      checkOutput({tag, "_ready"}, int'(o_ready), (size < DEPTH) ? 1 : 0);
      if (size > 0) begin
         checkOutput({tag, "_result"}, int'(o_result), int'(model_q[0].result));
         checkOutput({tag, "_flag"}, int'(o_flag), int'(model_q[0].flag));
      end else begin
         checkOutput({tag, "_result"}, int'(o_result), 0);
         checkOutput({tag, "_flag"}, int'(o_flag), 0);
      end
      checkOutput({tag, "_sticky_ovf"}, int'(o_sticky_ovf), int'(model_ovf));
      checkOutput({tag, "_sticky_neg"}, int'(o_sticky_neg), int'(model_neg));
`ifdef SCK_OVF_CNT_EN
      checkOutput({tag, "_ovf_cnt"}, int'(o_ovf_cnt), model_cnt);
`endif
   endtask

   // Called just after a rising edge; drives one cycle, advances the model and compares.
   task automatic applyStimulus(input logic valid, input logic signed [SCK_DATA_W-1:0] result,
                                input logic [SCK_FLAG_W-1:0] flag, input logic ready,
                                input logic clr, input string tag);
      bit push;
      bit pop;
      bit hit_ovf;
      bit hit_neg;
      sck_res_t ent;
      i_valid      = valid;
      i_result     = result;
      i_flag       = flag;
      i_ready      = ready;
      i_clr_sticky = clr;
      push    = valid && (model_q.size() < DEPTH);
      pop     = ready && (model_q.size() > 0);
      hit_ovf = push && flag[FLG_OVF];
      hit_neg = push && flag[FLG_NEG];
      @(posedge i_clk);
      #1;
      if (pop) void'(model_q.pop_front());
      if (push) begin
         ent.result = result;
         ent.flag   = flag;
         model_q.push_back(ent);
      end
      if (clr) begin
         model_ovf = hit_ovf;
         model_neg = hit_neg;
         model_cnt = hit_ovf ? 1 : 0;
      end else begin
         model_ovf = model_ovf | hit_ovf;
         model_neg = model_neg | hit_neg;
         if (hit_ovf && model_cnt < 255) model_cnt++;
      end
      compareModel(tag);
   endtask

   initial begin
      fill_tab[0] = '{1'b1, 10'sd5,    1'b0, 1, 1'b1, 1'b1, 10'sd5};
      fill_tab[1] = '{1'b1, -10'sd3,   1'b0, 2, 1'b1, 1'b1, 10'sd5};
      fill_tab[2] = '{1'b1, 10'sd0,    1'b0, 3, 1'b1, 1'b1, 10'sd5};
      fill_tab[3] = '{1'b1, 10'sd511,  1'b0, 4, 1'b1, 1'b0, 10'sd5};
      fill_tab[4] = '{1'b1, 10'sd100,  1'b0, 4, 1'b1, 1'b0, 10'sd5};
      fill_tab[5] = '{1'b0, 10'sd0,    1'b1, 3, 1'b1, 1'b1, -10'sd3};
      fill_tab[6] = '{1'b0, 10'sd0,    1'b1, 2, 1'b1, 1'b1, 10'sd0};
      fill_tab[7] = '{1'b0, 10'sd0,    1'b1, 1, 1'b1, 1'b1, 10'sd511};
      fill_tab[8] = '{1'b0, 10'sd0,    1'b1, 0, 1'b0, 1'b1, 10'sd0};

      i_rst        = 1'b1;
      i_valid      = 1'b0;
      i_result     = '0;
      i_flag       = '0;
      i_ready      = 1'b0;
      i_clr_sticky = 1'b0;
      modelReset();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      compareModel("reset");

      // Fill to full, refuse a fifth push, then drain in order.
      foreach (fill_tab[k]) begin
         applyStimulus(fill_tab[k].valid, fill_tab[k].result, 4'b0100, fill_tab[k].ready,
                       1'b0, "fill_model");
         checkOutput($sformatf("fill%0d_level", k), int'(o_level), fill_tab[k].exp_level);
         checkOutput($sformatf("fill%0d_valid", k), int'(o_valid), int'(fill_tab[k].exp_valid));
         checkOutput($sformatf("fill%0d_ready", k), int'(o_ready), int'(fill_tab[k].exp_ready));
         checkOutput($sformatf("fill%0d_head", k), int'(o_result), int'(fill_tab[k].exp_head));
      end

      // Concurrent push and pop at level 2 keeps the level constant.
      applyStimulus(1'b1, 10'sd20, 4'b0100, 1'b0, 1'b0, "conc_pre");
      applyStimulus(1'b1, 10'sd21, 4'b0100, 1'b0, 1'b0, "conc_pre");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, SCK_DATA_W'(30 + k), 4'b0100, 1'b1, 1'b0, "conc");
         checkOutput($sformatf("conc%0d_level", k), int'(o_level), 2);
         checkOutput($sformatf("conc%0d_head", k), int'(o_result), (k == 0) ? 21 : 29 + k);
      end
      repeat (2) applyStimulus(1'b0, 10'sd0, 4'b0000, 1'b1, 1'b0, "conc_drain");

      // Full with push and pop together: only the pop happens, push lands next cycle.
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, SCK_DATA_W'(-40 - k), 4'b1000, 1'b0, 1'b0, "fp_fill");
      applyStimulus(1'b1, 10'sd77, 4'b0010, 1'b1, 1'b0, "fp_both");
      checkOutput("fp_both_level", int'(o_level), 3);
      checkOutput("fp_both_head", int'(o_result), -41);
      applyStimulus(1'b1, 10'sd77, 4'b0010, 1'b0, 1'b0, "fp_land");
      checkOutput("fp_land_level", int'(o_level), 4);
      checkOutput("fp_land_ready", int'(o_ready), 0);
      repeat (4) applyStimulus(1'b0, 10'sd0, 4'b0000, 1'b1, 1'b0, "fp_drain");

      // Reset asserted mid-stream with three entries held.
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, SCK_DATA_W'(k + 1), 4'b1001, 1'b0, 1'b0, "rst_fill");
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", int'(o_valid), 0);
      checkOutput("async_rst_level", int'(o_level), 0);
      checkOutput("async_rst_ready", int'(o_ready), 1);
      checkOutput("async_rst_sticky_ovf", int'(o_sticky_ovf), 0);
      checkOutput("async_rst_sticky_neg", int'(o_sticky_neg), 0);
      modelReset();
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      compareModel("after_rst");

      // Sticky set, clear racing a setting push, then a plain clear.
      applyStimulus(1'b1, 10'sd1, 4'b0001, 1'b1, 1'b0, "sticky_set");
      checkOutput("sticky_set_ovf", int'(o_sticky_ovf), 1);
      applyStimulus(1'b1, -10'sd2, 4'b1000, 1'b1, 1'b1, "sticky_race");
      checkOutput("sticky_race_ovf", int'(o_sticky_ovf), 0);
      checkOutput("sticky_race_neg", int'(o_sticky_neg), 1);
      applyStimulus(1'b0, 10'sd0, 4'b0000, 1'b1, 1'b1, "sticky_clr");
      checkOutput("sticky_clr_ovf", int'(o_sticky_ovf), 0);
      checkOutput("sticky_clr_neg", int'(o_sticky_neg), 0);

`ifdef SCK_OVF_CNT_EN
      for (int k = 0; k < 260; k++) applyStimulus(1'b1, SCK_DATA_W'(k), 4'b0001, 1'b1, 1'b0, "cnt");
      checkOutput("cnt_saturate", int'(o_ovf_cnt), 255);
      applyStimulus(1'b0, 10'sd0, 4'b0000, 1'b1, 1'b1, "cnt_clr");
      checkOutput("cnt_clear", int'(o_ovf_cnt), 0);
`endif

      // Randomized traffic against the queue model.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), SCK_DATA_W'($urandom), 4'($urandom),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
